clock_divider_bank: RTL and testbench

//  Derives the eight slow clocks consumed by the processor's clock selector:
//  1 Hz, 10 Hz, 100 Hz, 1 kHz, 10 kHz, 100 kHz, 1 MHz and ~12 MHz.

---
 rtl/clock_divider_bank.sv | 130 +++++++++++++
 tb/tb_clock_divider_bank.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// Clock divider bank: 1 MHz base divider, six cascaded decade stages (100 kHz .. 1 Hz) and a fast divider.
// Defining DIVIDER_STROBE_EN adds tick[7:0], a registered one-cycle strobe in the last cycle of each output period.

module clock_divider_bank #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int HALF_12M    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sync_clr,
    output logic       clock_1hz,
    output logic       clock_10hz,
    output logic       clock_100hz,
    output logic       clock_1khz,
    output logic       clock_10khz,
    output logic       clock_100khz,
    output logic       clock_1mhz,
    output logic       clock_12mhz
`ifdef DIVIDER_STROBE_EN
    ,
    output logic [7:0] tick
`endif
);

    localparam int DIV     = CLK_FREQ_HZ / 1_000_000;
    localparam int HALF    = DIV / 2;
    localparam int CB_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int C12_W   = (HALF_12M > 1) ? $clog2(HALF_12M) : 1;
    localparam int NUM_DEC = 6;

    localparam logic [CB_W-1:0]  CB_MID     = CB_W'(HALF - 1);
    localparam logic [CB_W-1:0]  CB_LAST    = CB_W'(DIV - 1);
    localparam logic [C12_W-1:0] C12_LAST   = C12_W'(HALF_12M - 1);
    localparam logic [3:0]       MID_DIGIT  = 4'd4;
    localparam logic [3:0]       LAST_DIGIT = 4'd9;

    logic [CB_W-1:0]         cb_q, cb_nx;
    logic [C12_W-1:0]        c12_q, c12_nx;
    logic [NUM_DEC-1:0][3:0] cd_q, cd_nx;      // index 0 = 100 kHz stage, 5 = 1 Hz stage
    logic [NUM_DEC-1:0]      dec_clk_q, dec_tog;
    logic                    mhz_q, mhz_tog;
    logic                    fast_q, c12_wrap;
    logic                    chain;

    // Next-state logic; 'chain' is the parent strobe walking down the decade cascade.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        cd_nx   = cd_q;
        dec_tog = '0;

        mhz_tog = (cb_q == CB_MID) || (cb_q == CB_LAST);
        chain   = (cb_q == CB_LAST);
        cb_nx   = chain ? '0 : cb_q + 1'b1;

        for (int k = 0; k < NUM_DEC; k++) begin
            if (chain) begin
                cd_nx[k]   = (cd_q[k] == LAST_DIGIT) ? 4'd0 : cd_q[k] + 4'd1;
                dec_tog[k] = (cd_q[k] == MID_DIGIT) || (cd_q[k] == LAST_DIGIT);
            end
            chain = chain && (cd_q[k] == LAST_DIGIT);
        end

        c12_wrap = (c12_q == C12_LAST);
        c12_nx   = c12_wrap ? '0 : c12_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cb_q      <= '0;
            cd_q      <= '0;
            c12_q     <= '0;
            mhz_q     <= 1'b0;
            dec_clk_q <= '0;
            fast_q    <= 1'b0;
        end else if (sync_clr) begin
            cb_q      <= '0;
            cd_q      <= '0;
            c12_q     <= '0;
            mhz_q     <= 1'b0;
            dec_clk_q <= '0;
            fast_q    <= 1'b0;
        end else begin
            cb_q      <= cb_nx;
            cd_q      <= cd_nx;
            c12_q     <= c12_nx;
            mhz_q     <= mhz_q ^ mhz_tog;
            dec_clk_q <= dec_clk_q ^ dec_tog;
            fast_q    <= fast_q ^ c12_wrap;
        end
    end

    assign clock_1mhz   = mhz_q;
    assign clock_100khz = dec_clk_q[0];
    assign clock_10khz  = dec_clk_q[1];
    assign clock_1khz   = dec_clk_q[2];
    assign clock_100hz  = dec_clk_q[3];
    assign clock_10hz   = dec_clk_q[4];
    assign clock_1hz    = dec_clk_q[5];
    assign clock_12mhz  = fast_q;

`ifdef DIVIDER_STROBE_EN
    logic [7:0] tick_nx;
    logic       chain_nx;

    // Strobes are predicted from next-state values so the registered tick lines up with the internal strobe cycle.
    always_comb begin
        tick_nx    = '0;
        chain_nx   = (cb_nx == CB_LAST);
        tick_nx[6] = chain_nx;
        for (int k = 0; k < NUM_DEC; k++) begin
            chain_nx       = chain_nx && (cd_nx[k] == LAST_DIGIT);
            tick_nx[5 - k] = chain_nx;
        end
        // The fast clock's period ends at the wrap that drives it low.
        tick_nx[7] = (c12_nx == C12_LAST) && (fast_q ^ c12_wrap);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (sync_clr) begin
            tick <= '0;
        end else begin
            tick <= tick_nx;
        end
    end
`endif

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: a 2 MHz instance (HALF_12M=1) and a 50 MHz instance (HALF_12M=2).
// Expected waveforms come from a square-wave model: output with half-period H is high after edge n when floor(n/H) is odd.

module tb_clock_divider_bank;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic sync_clr = 1'b0;

    logic a_1hz, a_10hz, a_100hz, a_1khz, a_10khz, a_100khz, a_1mhz, a_12mhz;
    logic b_1hz, b_10hz, b_100hz, b_1khz, b_10khz, b_100khz, b_1mhz, b_12mhz;
    logic [7:0] obs_a, obs_b;
`ifdef DIVIDER_STROBE_EN
    logic [7:0] a_tick, b_tick;
`endif

    int     vectors     = 0;
    int     miscompares = 0;
    longint edge_n      = 0;

    clock_divider_bank #(.CLK_FREQ_HZ(2_000_000), .HALF_12M(1)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .sync_clr    (sync_clr),
        .clock_1hz   (a_1hz),
        .clock_10hz  (a_10hz),
        .clock_100hz (a_100hz),
        .clock_1khz  (a_1khz),
        .clock_10khz (a_10khz),
        .clock_100khz(a_100khz),
        .clock_1mhz  (a_1mhz),
        .clock_12mhz (a_12mhz)
`ifdef DIVIDER_STROBE_EN
        ,
        .tick        (a_tick)
`endif
    );

    clock_divider_bank #(.CLK_FREQ_HZ(50_000_000), .HALF_12M(2)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .sync_clr    (sync_clr),
        .clock_1hz   (b_1hz),
        .clock_10hz  (b_10hz),
        .clock_100hz (b_100hz),
        .clock_1khz  (b_1khz),
        .clock_10khz (b_10khz),
        .clock_100khz(b_100khz),
        .clock_1mhz  (b_1mhz),
        .clock_12mhz (b_12mhz)
`ifdef DIVIDER_STROBE_EN
        ,
        .tick        (b_tick)
`endif
    );

    // Bit order matches the tick/sel codes: 0 = 1 Hz .. 6 = 1 MHz, 7 = fast clock.
    assign obs_a = {a_12mhz, a_1mhz, a_100khz, a_10khz, a_1khz, a_100hz, a_10hz, a_1hz};
    assign obs_b = {b_12mhz, b_1mhz, b_100khz, b_10khz, b_1khz, b_100hz, b_10hz, b_1hz};

    always #5 clock = ~clock;

    function automatic logic [7:0] model_clocks(input longint n, input longint h1m, input longint h12);
        logic [7:0] v;
        longint     h;
        v[7] = ((n / h12) % 2) != 0;
        v[6] = ((n / h1m) % 2) != 0;
        h = h1m;
        for (int b = 5; b >= 0; b--) begin
            h    = h * 10;
            v[b] = ((n / h) % 2) != 0;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_ticks(input longint n, input longint h1m, input longint h12);
        logic [7:0] v;
        longint     h;
        v[7] = ((n + 1) % (2 * h12)) == 0;
        v[6] = ((n + 1) % (2 * h1m)) == 0;
        h = h1m;
        for (int b = 5; b >= 0; b--) begin
            h    = h * 10;
            v[b] = ((n + 1) % (2 * h)) == 0;
        end
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            edge_n++;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        vectors++;
        if (obs_a !== 8'h00 || obs_b !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold: observed a=%b b=%b, expected 00000000 both", obs_a, obs_b);
        end
`ifdef DIVIDER_STROBE_EN
        vectors++;
        if (a_tick !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_tick: observed %b, expected 00000000", a_tick);
        end
`endif
        reset  = 1'b0;
        edge_n = 0;
        vectors++;
        if (obs_a !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release: observed %b, expected 00000000", obs_a);
        end
        step(1);
        vectors++;
        if (obs_a !== 8'hC0) begin
            miscompares++;
            $display("FAIL first_edge: observed %b, expected 11000000", obs_a);
        end
        step(1);
        vectors++;
        if (obs_a !== 8'h00) begin
            miscompares++;
            $display("FAIL second_edge: observed %b, expected 00000000", obs_a);
        end
    endtask

    // Continues from edge 2 after test_reset up to edge 20000: full 1 kHz x10 and one full 100 Hz period.
    task automatic test_decade_chain();
        logic [7:0] prev, exp_v;
        int         rises_1k = 0;
        longint     first_1k = -1, first_100hz = -1, fall_100hz = -1;
`ifdef DIVIDER_STROBE_EN
        logic [7:0] exp_t;
        int         count_t2 = 0;
        longint     first_t2 = -1;
`endif
        prev = obs_a;
        while (edge_n < 20_000) begin
            step(1);
            exp_v = model_clocks(edge_n, 1, 1);
            vectors++;
            if (obs_a !== exp_v) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL chain_clocks: observed %b, expected %b at edge %0d", obs_a, exp_v, edge_n);
            end
            for (int b = 2; b <= 5; b++) begin
                if (!prev[b] && obs_a[b]) begin
                    vectors++;
                    if (!(prev[b+1] === 1'b1 && obs_a[b+1] === 1'b0)) begin
                        miscompares++;
                        $display("FAIL align_bit%0d: parent went %b->%b, expected 1->0 at edge %0d",
                                 b, prev[b+1], obs_a[b+1], edge_n);
                    end
                end
            end
            if (!prev[3] && obs_a[3]) begin
                rises_1k++;
                if (first_1k < 0) first_1k = edge_n;
            end
            if (!prev[2] && obs_a[2] && first_100hz < 0) first_100hz = edge_n;
            if (prev[2] && !obs_a[2] && fall_100hz < 0) fall_100hz = edge_n;
`ifdef DIVIDER_STROBE_EN
            exp_t = model_ticks(edge_n, 1, 1);
            vectors++;
            if (a_tick !== exp_t) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL chain_ticks: observed %b, expected %b at edge %0d", a_tick, exp_t, edge_n);
            end
            if (a_tick[2] === 1'b1) begin
                count_t2++;
                if (first_t2 < 0) first_t2 = edge_n;
            end
`endif
            prev = obs_a;
        end
        vectors++;
        if (first_1k != 1000) begin
            miscompares++;
            $display("FAIL first_1khz_rise: observed edge %0d, expected edge 1000", first_1k);
        end
        vectors++;
        if (rises_1k != 10) begin
            miscompares++;
            $display("FAIL periods_1khz: observed %0d, expected 10", rises_1k);
        end
        vectors++;
        if (first_100hz != 10_000 || fall_100hz != 20_000) begin
            miscompares++;
            $display("FAIL edges_100hz: observed rise %0d fall %0d, expected rise 10000 fall 20000",
                     first_100hz, fall_100hz);
        end
`ifdef DIVIDER_STROBE_EN
        vectors++;
        if (count_t2 != 1 || first_t2 != 19_999) begin
            miscompares++;
            $display("FAIL tick_100hz: observed %0d pulses first at %0d, expected 1 pulse at 19999", count_t2, first_t2);
        end
`endif
    endtask

    task automatic test_sync_clr();
        logic [7:0] exp_v;
        apply_reset();
        step(776);
        vectors++;
        if (obs_a !== 8'h30) begin
            miscompares++;
            $display("FAIL pre_clr_776: observed %b, expected 00110000", obs_a);
        end
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        vectors++;
        if (obs_a !== 8'h00 || obs_b !== 8'h00) begin
            miscompares++;
            $display("FAIL sync_clr_777: observed a=%b b=%b, expected 00000000 both", obs_a, obs_b);
        end
        edge_n = 0;
        step(1);
        vectors++;
        if (obs_a !== 8'hC0) begin
            miscompares++;
            $display("FAIL clr_first_edge: observed %b, expected 11000000", obs_a);
        end
        while (edge_n < 40) begin
            step(1);
            exp_v = model_clocks(edge_n, 1, 1);
            vectors++;
            if (obs_a !== exp_v) begin
                miscompares++;
                $display("FAIL clr_restart: observed %b, expected %b at edge %0d", obs_a, exp_v, edge_n);
            end
        end
    endtask

    task automatic test_async_reset();
        step(15);
        vectors++;
        if (obs_a !== 8'hE0) begin
            miscompares++;
            $display("FAIL pre_reset_55: observed %b, expected 11100000", obs_a);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs_a !== 8'h00 || obs_b !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset_drop: observed a=%b b=%b, expected 00000000 both", obs_a, obs_b);
        end
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        step(1);
        vectors++;
        if (obs_a !== 8'hC0) begin
            miscompares++;
            $display("FAIL reset_restart: observed %b, expected 11000000", obs_a);
        end
    endtask

    task automatic test_fast_board();
        logic [7:0] prev, exp_v;
        longint     rise_1m = -1, fall_1m = -1;
        int         rises_12m = 0;
        apply_reset();
        prev = obs_b;
        while (edge_n < 120) begin
            step(1);
            exp_v = model_clocks(edge_n, 25, 2);
            vectors++;
            if (obs_b !== exp_v) begin
                miscompares++;
                $display("FAIL fast_board: observed %b, expected %b at edge %0d", obs_b, exp_v, edge_n);
            end
            if (!prev[6] && obs_b[6] && rise_1m < 0) rise_1m = edge_n;
            if (prev[6] && !obs_b[6] && fall_1m < 0) fall_1m = edge_n;
            if (!prev[7] && obs_b[7]) rises_12m++;
            prev = obs_b;
        end
        vectors++;
        if (rise_1m != 25 || fall_1m != 50) begin
            miscompares++;
            $display("FAIL fast_1mhz_edges: observed rise %0d fall %0d, expected rise 25 fall 50", rise_1m, fall_1m);
        end
        vectors++;
        if (rises_12m != 30) begin
            miscompares++;
            $display("FAIL fast_12mhz_period: observed %0d rises in 120 edges, expected 30", rises_12m);
        end
    endtask

`ifdef DIVIDER_STROBE_EN
    task automatic test_ticks();
        int   pulses6 = 0, pulses7 = 0, doubles = 0;
        logic prev6 = 1'b0;
        apply_reset();
        while (edge_n < 100) begin
            step(1);
            if (a_tick[6] === 1'b1) pulses6++;
            if (a_tick[7] === 1'b1) pulses7++;
            if (prev6 === 1'b1 && a_tick[6] === 1'b1) doubles++;
            prev6 = a_tick[6];
        end
        vectors++;
        if (pulses6 != 50 || doubles != 0) begin
            miscompares++;
            $display("FAIL tick_1mhz: observed %0d pulses %0d doubled, expected 50 pulses 0 doubled", pulses6, doubles);
        end
        vectors++;
        if (pulses7 != 50) begin
            miscompares++;
            $display("FAIL tick_fast: observed %0d pulses, expected 50", pulses7);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decade_chain();
        test_sync_clr();
        test_async_reset();
        test_fast_board();
`ifdef DIVIDER_STROBE_EN
        test_ticks();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
